// File: rtl/set_job_sched.sv
// set_job_sched
//
// Round-robin front end for a single shared SET candidate-count engine.
// Up to NREQ requesters post jobs (central/radius/mode); one job at a time is
// granted, issued to the engine with a one-cycle eng_en, and its result (or a
// timeout error) is returned to the owning requester with a one-hot strobe.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   req_valid       : per-requester job pending (held until req_ack)
//   req_central     : per-requester central, slice i = [24*i+23:24*i]
//   req_radius      : per-requester radius,  slice i = [12*i+11:12*i]
//   req_mode        : per-requester mode,    slice i = [2*i+1:2*i]
//   req_ack         : one-hot pulse, job of requester i accepted
//   rsp_valid       : one-hot pulse, result for requester i
//   rsp_candidate   : result count (0 unless a response is being sent)
//   rsp_err         : response is a timeout (rsp_candidate = 0)
//   eng_en          : one-cycle job start to the engine
//   eng_central/eng_radius/eng_mode : payload of the last granted job
//   eng_busy        : engine not ready, blocks a new grant
//   eng_valid       : engine result valid
//   eng_candidate   : engine result
//   done_cnt        : completed jobs including errors (wraps)
//   err_cnt         : timed-out jobs (saturates at 0xFF)
module set_job_sched #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*24-1:0]   req_central,
  input  logic [NREQ*12-1:0]   req_radius,
  input  logic [NREQ*2-1:0]    req_mode,
  output logic [NREQ-1:0]      req_ack,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [7:0]           rsp_candidate,
  output logic                 rsp_err,
  output logic                 eng_en,
  output logic [23:0]          eng_central,
  output logic [11:0]          eng_radius,
  output logic [1:0]           eng_mode,
  input  logic                 eng_busy,
  input  logic                 eng_valid,
  input  logic [7:0]           eng_candidate,
  output logic [15:0]          done_cnt,
  output logic [7:0]           err_cnt
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  // WAIT leaves at TIMEOUT-1, so the counter never needs to hold TIMEOUT.
  localparam int TMO_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [7:0]         cand_d;
  logic               err_d;
  logic               latch_job;

  logic [NREQ-1:0]    req_ack_q;
  logic [NREQ-1:0]    rsp_valid_q;
  logic [7:0]         rsp_candidate_q;
  logic               rsp_err_q;
  logic               eng_en_q;
  logic [23:0]        eng_central_q;
  logic [11:0]        eng_radius_q;
  logic [1:0]         eng_mode_q;
  logic [15:0]        done_cnt_q;
  logic [7:0]         err_cnt_q;

  logic               grant_vld;
  logic [PTR_W-1:0]   grant_idx;

  // Requester index k steps after ptr, modulo NREQ.
  function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] ptr, input int k);
    int s;
    s = int'(ptr) + k;
    if (s >= NREQ) s = s - NREQ;
    return PTR_W'(s);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [NREQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Round-robin search: scanning from the far end down to rr_ptr+1 lets the
  // candidate nearest to rr_ptr+1 overwrite the others, so it wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[rr_idx(rr_ptr_q, k)]) begin
        grant_vld = 1'b1;
        grant_idx = rr_idx(rr_ptr_q, k);
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    tmo_d     = tmo_q;
    cand_d    = 8'd0;
    err_d     = 1'b0;
    latch_job = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (grant_vld && !eng_busy && !eng_valid) begin
          state_d   = S_ISSUE;
          owner_d   = grant_idx;
          rr_ptr_d  = grant_idx;
          latch_job = 1'b1;
        end
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tmo_d = tmo_q + 1'b1;
        // A result in the last allowed cycle still counts as a result.
        if (eng_valid) begin
          cand_d  = eng_candidate;
          state_d = S_RESP;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Hold off the next job until the engine drops valid, so a stretched
        // or late valid is never credited to a new owner.
        if (!eng_valid) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; strobes are decoded from the next state so
  // they are high exactly during ISSUE / RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      rr_ptr_q        <= PTR_W'(NREQ - 1);
      owner_q         <= '0;
      tmo_q           <= '0;
      req_ack_q       <= '0;
      rsp_valid_q     <= '0;
      rsp_candidate_q <= 8'd0;
      rsp_err_q       <= 1'b0;
      eng_en_q        <= 1'b0;
      eng_central_q   <= 24'd0;
      eng_radius_q    <= 12'd0;
      eng_mode_q      <= 2'd0;
      done_cnt_q      <= 16'd0;
      err_cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      tmo_q       <= tmo_d;
      eng_en_q    <= (state_d == S_ISSUE);
      req_ack_q   <= (state_d == S_ISSUE) ? onehot(owner_d) : '0;
      rsp_valid_q <= (state_d == S_RESP) ? onehot(owner_d) : '0;
      // cand_d / err_d are non-zero only on the WAIT -> RESP transition.
      rsp_candidate_q <= cand_d;
      rsp_err_q       <= err_d;
      if (latch_job) begin
        eng_central_q <= req_central[24*grant_idx +: 24];
        eng_radius_q  <= req_radius[12*grant_idx +: 12];
        eng_mode_q    <= req_mode[2*grant_idx +: 2];
      end
      if (state_q == S_RESP) begin
        done_cnt_q <= done_cnt_q + 16'd1;
        if (rsp_err_q) err_cnt_q <= sat_inc8(err_cnt_q);
      end
    end
  end

  assign req_ack       = req_ack_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_candidate = rsp_candidate_q;
  assign rsp_err       = rsp_err_q;
  assign eng_en        = eng_en_q;
  assign eng_central   = eng_central_q;
  assign eng_radius    = eng_radius_q;
  assign eng_mode      = eng_mode_q;
  assign done_cnt      = done_cnt_q;
  assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_set_job_sched.sv
`timescale 1ns/1ps
module tb_set_job_sched;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 128;

  logic                clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*24-1:0]  req_central;
  logic [NREQ*12-1:0]  req_radius;
  logic [NREQ*2-1:0]   req_mode;
  logic [NREQ-1:0]     req_ack;
  logic [NREQ-1:0]     rsp_valid;
  logic [7:0]          rsp_candidate;
  logic                rsp_err;
  logic                eng_en;
  logic [23:0]         eng_central;
  logic [11:0]         eng_radius;
  logic [1:0]          eng_mode;
  logic                eng_busy;
  logic                eng_valid;
  logic [7:0]          eng_candidate;
  logic [15:0]         done_cnt;
  logic [7:0]          err_cnt;

  set_job_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_central(req_central), .req_radius(req_radius),
    .req_mode(req_mode), .req_ack(req_ack), .rsp_valid(rsp_valid),
    .rsp_candidate(rsp_candidate), .rsp_err(rsp_err), .eng_en(eng_en),
    .eng_central(eng_central), .eng_radius(eng_radius), .eng_mode(eng_mode),
    .eng_busy(eng_busy), .eng_valid(eng_valid), .eng_candidate(eng_candidate),
    .done_cnt(done_cnt), .err_cnt(err_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;

  // Engine behaviour for the current job
  bit        e_pend = 0, e_never = 0, e_rand = 0;
  int        e_t0 = 0, e_delay = 1, e_hold = 1;
  logic [7:0] e_cand = 8'd0;

  // Reference model (transaction level)
  bit         m_idle = 0, m_drain = 0, m_gp = 0, m_inflight = 0;
  int         m_wp = 0, m_last = NREQ - 1, m_owner = 0, m_drain_from = 0;
  int         m_rsp_cyc = 0;
  logic [7:0] m_rsp_cand = 8'd0;
  bit         m_rsp_err = 0;
  logic [15:0] m_done = 16'd0;
  int         m_err = 0;
  logic [23:0] m_c = 0, s_c = 0;
  logic [11:0] m_r = 0, s_r = 0;
  logic [1:0]  m_m = 0, s_m = 0;

  // Requester behaviour: 0 drop on ack, 1 reload on ack, 2 random traffic
  int tb_mode = 0;
  bit ackd [NREQ];

  // Observation records
  int         last_ack_cyc = -1, last_en_cyc = -1, last_rsp_cyc = -1;
  logic [NREQ-1:0] last_ack_vec = '0, last_rsp_vec = '0;
  logic [7:0] last_rsp_cand = 8'd0;
  logic       last_rsp_err = 1'b0;
  int         rsp_pulses = 0, ack_pulses = 0, en_pulses = 0;
  int         grant_log[$];
  int         ack_cycs[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic new_job(input int i);
    req_valid[i] = 1'b1;
    req_central[24*i +: 24] = 24'($urandom);
    req_radius[12*i +: 12]  = 12'($urandom);
    req_mode[2*i +: 2]      = 2'($urandom);
  endtask

  // One clock cycle: predict from the inputs of the ending cycle, check the
  // new cycle's outputs, then drive engine and requester inputs.
  task automatic cyc();
    bit g, rnow, exp_rsp;
    int w;
    rnow = rst;
    g = 0;
    w = 0;
    if (!rnow && m_idle && (|req_valid) && !eng_busy && !eng_valid) begin
      for (int k = 1; k <= NREQ; k++) begin
        int i;
        i = (m_last + k) % NREQ;
        if (!g && req_valid[i]) begin
          g = 1;
          w = i;
        end
      end
      if (g) begin
        m_idle = 0;
        s_c = req_central[24*w +: 24];
        s_r = req_radius[12*w +: 12];
        s_m = req_mode[2*w +: 2];
      end
    end
    if (m_drain && cyc_n >= m_drain_from && !eng_valid) begin
      m_drain = 0;
      m_idle  = 1;
    end
    m_gp = g;
    m_wp = w;

    @(posedge clk);
    #1;
    cyc_n++;

    if (rnow) begin
      chk("rst_ack", 32'(req_ack), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_cand", 32'(rsp_candidate), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_eng_en", 32'(eng_en), 32'd0);
      chk("rst_eng_central", 32'(eng_central), 32'd0);
      chk("rst_eng_radius", 32'(eng_radius), 32'd0);
      chk("rst_eng_mode", 32'(eng_mode), 32'd0);
      chk("rst_done_cnt", 32'(done_cnt), 32'd0);
      chk("rst_err_cnt", 32'(err_cnt), 32'd0);
      m_idle = 1; m_drain = 0; m_gp = 0; m_inflight = 0;
      m_last = NREQ - 1; m_done = 16'd0; m_err = 0;
      m_c = 0; m_r = 0; m_m = 0;
    end else begin
      chk("ack", 32'(req_ack), m_gp ? 32'(1 << m_wp) : 32'd0);
      chk("eng_en", 32'(eng_en), 32'(m_gp));
      if (m_gp) begin
        m_inflight = 1; m_owner = m_wp; m_last = m_wp;
        m_c = s_c; m_r = s_r; m_m = s_m;
        grant_log.push_back(m_wp);
        if (e_rand) begin
          e_never = 0;
          e_delay = $urandom_range(1, 30);
          e_hold  = $urandom_range(1, 3);
          e_cand  = 8'($urandom);
        end
        if (e_never || e_delay > TIMEOUT) begin
          m_rsp_cyc = cyc_n + TIMEOUT + 1; m_rsp_cand = 8'd0; m_rsp_err = 1;
        end else begin
          m_rsp_cyc = cyc_n + e_delay + 1; m_rsp_cand = e_cand; m_rsp_err = 0;
        end
      end
      chk("eng_central", 32'(eng_central), 32'(m_c));
      chk("eng_radius", 32'(eng_radius), 32'(m_r));
      chk("eng_mode", 32'(eng_mode), 32'(m_m));
      chk("done_cnt", 32'(done_cnt), 32'(m_done));
      chk("err_cnt", 32'(err_cnt), 32'(m_err));
      exp_rsp = m_inflight && (cyc_n == m_rsp_cyc);
      chk("rsp_valid", 32'(rsp_valid), exp_rsp ? 32'(1 << m_owner) : 32'd0);
      chk("rsp_cand", 32'(rsp_candidate), exp_rsp ? 32'(m_rsp_cand) : 32'd0);
      chk("rsp_err", 32'(rsp_err), exp_rsp ? 32'(m_rsp_err) : 32'd0);
      if (exp_rsp) begin
        m_inflight = 0; m_drain = 1; m_drain_from = cyc_n + 1;
        m_done = m_done + 16'd1;
        if (m_rsp_err && m_err < 255) m_err++;
      end
    end

    // Observation records
    if (|req_ack) begin
      last_ack_cyc = cyc_n; last_ack_vec = req_ack; ack_pulses++;
      ack_cycs.push_back(cyc_n);
    end
    if (|rsp_valid) begin
      last_rsp_cyc = cyc_n; last_rsp_vec = rsp_valid;
      last_rsp_cand = rsp_candidate; last_rsp_err = rsp_err; rsp_pulses++;
    end
    if (eng_en) begin
      if (last_en_cyc >= 0) chk("en_gap_ge5", 32'((cyc_n - last_en_cyc) >= 5), 32'd1);
      last_en_cyc = cyc_n; en_pulses++;
      e_pend = 1; e_t0 = cyc_n;
    end

    // Engine drive for this cycle
    eng_valid = e_pend && !e_never && ((cyc_n - e_t0) >= e_delay) &&
                ((cyc_n - e_t0) < e_delay + e_hold);
    eng_candidate = eng_valid ? e_cand : 8'($urandom);

    // Requesters keep the job through the ack cycle and react one cycle later
    for (int i = 0; i < NREQ; i++) begin
      if (ackd[i]) begin
        ackd[i] = 0;
        if (tb_mode == 1) new_job(i);
        else req_valid[i] = 1'b0;
      end else if (req_ack[i]) begin
        ackd[i] = 1;
      end else if (tb_mode == 2) begin
        if (!req_valid[i] && $urandom_range(0, 7) == 0) new_job(i);
        else if (req_valid[i] && $urandom_range(0, 31) == 0) req_valid[i] = 1'b0;
      end
    end
    if (tb_mode == 2 && $urandom_range(0, 15) == 0) eng_busy = ~eng_busy;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    run(n);
    rst = 1'b0;
  endtask

  int t0;

  initial begin
    rst = 1'b1; req_valid = '0; req_central = '0; req_radius = '0; req_mode = '0;
    eng_busy = 1'b0; eng_valid = 1'b0; eng_candidate = 8'd0;
    for (int i = 0; i < NREQ; i++) ackd[i] = 0;
    do_reset(2);

    // Single job on requester 0
    tb_mode = 0; e_rand = 0; e_never = 0; e_delay = 66; e_hold = 1; e_cand = 8'd29;
    req_valid[0] = 1'b1; req_central[23:0] = 24'h444000;
    req_radius[11:0] = 12'h300; req_mode[1:0] = 2'd0;
    t0 = cyc_n; rsp_pulses = 0;
    run(1);
    chk("single_ack_cyc", 32'(last_ack_cyc), 32'(t0 + 1));
    chk("single_ack_vec", 32'(last_ack_vec), 32'h1);
    run(80);
    chk("single_rsp_cyc", 32'(last_rsp_cyc), 32'(t0 + 1 + 66 + 1));
    chk("single_rsp_vec", 32'(last_rsp_vec), 32'h1);
    chk("single_rsp_cand", 32'(last_rsp_cand), 32'd29);
    chk("single_rsp_err", 32'(last_rsp_err), 32'd0);
    chk("single_pulses", 32'(rsp_pulses), 32'd1);
    chk("single_done", 32'(done_cnt), 32'd1);

    // All requesters pending continuously from reset
    tb_mode = 1; e_rand = 1;
    for (int i = 0; i < NREQ; i++) new_job(i);
    do_reset(1);
    grant_log.delete();
    run(400);
    chk("cont_jobs", 32'(grant_log.size() >= 8), 32'd1);
    for (int k = 0; k < grant_log.size(); k++)
      chk("cont_order", 32'(grant_log[k]), 32'(k % NREQ));
    tb_mode = 0;
    run(250);

    // Timeout with a late valid landing in DRAIN
    e_rand = 0; e_never = 0; e_delay = TIMEOUT + 1; e_hold = 3; e_cand = 8'hA5;
    new_job(1); t0 = cyc_n; rsp_pulses = 0;
    run(TIMEOUT + 15);
    chk("tmo_rsp_cyc", 32'(last_rsp_cyc), 32'(t0 + 1 + TIMEOUT + 1));
    chk("tmo_rsp_vec", 32'(last_rsp_vec), 32'h2);
    chk("tmo_rsp_err", 32'(last_rsp_err), 32'd1);
    chk("tmo_rsp_cand", 32'(last_rsp_cand), 32'd0);
    chk("tmo_err_cnt", 32'(err_cnt), 32'd1);
    chk("tmo_late_absorbed", 32'(rsp_pulses), 32'd1);

    // Valid in the very last WAIT cycle beats the timeout
    e_delay = TIMEOUT; e_hold = 1; e_cand = 8'h5A;
    new_job(2); t0 = cyc_n;
    run(TIMEOUT + 10);
    chk("edge_rsp_cyc", 32'(last_rsp_cyc), 32'(t0 + 1 + TIMEOUT + 1));
    chk("edge_rsp_err", 32'(last_rsp_err), 32'd0);
    chk("edge_rsp_cand", 32'(last_rsp_cand), 32'h5A);
    chk("edge_err_cnt", 32'(err_cnt), 32'd1);

    // Engine silent
    e_never = 1;
    new_job(3);
    run(TIMEOUT + 10);
    chk("never_rsp_err", 32'(last_rsp_err), 32'd1);
    chk("never_err_cnt", 32'(err_cnt), 32'd2);
    e_never = 0;

    // eng_busy blocks issue
    e_delay = 8; e_hold = 1; e_cand = 8'h11;
    eng_busy = 1'b1; new_job(2); ack_pulses = 0; en_pulses = 0;
    run(10);
    chk("busy_no_ack", 32'(ack_pulses), 32'd0);
    chk("busy_no_en", 32'(en_pulses), 32'd0);
    eng_busy = 1'b0; t0 = cyc_n;
    run(1);
    chk("busy_ack_cyc", 32'(last_ack_cyc), 32'(t0 + 1));
    chk("busy_ack_vec", 32'(last_ack_vec), 32'h4);
    run(20);

    // Stretched engine valid: one response, next grant after DRAIN
    e_delay = 5; e_hold = 3; e_cand = 8'h42;
    new_job(0); new_job(1); ack_cycs.delete(); rsp_pulses = 0;
    run(40);
    chk("hold_acks", 32'(ack_cycs.size()), 32'd2);
    if (ack_cycs.size() == 2)
      chk("hold_ack_gap", 32'(ack_cycs[1] - ack_cycs[0]), 32'd10);
    chk("hold_rsp_pulses", 32'(rsp_pulses), 32'd2);

    // Reset while waiting on the engine
    e_delay = 66; e_hold = 1; e_cand = 8'h07;
    new_job(3);
    run(1);
    run(19);
    do_reset(1);
    rsp_pulses = 0;
    e_delay = 10; e_cand = 8'h33;
    new_job(1);
    run(40);
    chk("rwait_pulses", 32'(rsp_pulses), 32'd1);
    chk("rwait_rsp_vec", 32'(last_rsp_vec), 32'h2);
    chk("rwait_rsp_cand", 32'(last_rsp_cand), 32'h33);
    chk("rwait_done", 32'(done_cnt), 32'd1);

    // Random traffic with withdrawals and busy toggling
    tb_mode = 2; e_rand = 1; grant_log.delete();
    run(1500);
    tb_mode = 0; eng_busy = 1'b0;
    run(300);
    chk("rand_jobs", 32'(grant_log.size() > 10), 32'd1);

    do_reset(1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
